// File: rtl/lb_arbiter.sv
// Round-robin local-bus arbiter: C_CH_NUM requesters share one slave bus, one read outstanding.
// Optional read watchdog compiled in with LB_ARB_WATCHDOG_EN.
module lb_arbiter #(
  parameter int C_ADDR_WIDTH = 16,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_CH_NUM     = 2,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                             LB_CLK_I,
  input  logic                             LB_RSTN_I,
  input  logic [C_CH_NUM*C_ADDR_WIDTH-1:0] LB_WADDR_I,
  input  logic [C_CH_NUM*C_DATA_WIDTH-1:0] LB_WDATA_I,
  input  logic [C_CH_NUM-1:0]              LB_WREQ_I,
  input  logic [C_CH_NUM*C_ADDR_WIDTH-1:0] LB_RADDR_I,
  input  logic [C_CH_NUM-1:0]              LB_RREQ_I,
  output logic [C_CH_NUM*C_DATA_WIDTH-1:0] LB_RDATA_O,
  output logic [C_CH_NUM-1:0]              LB_RFINISH_O,
  output logic [C_CH_NUM-1:0]              LB_OVF_O,
  output logic [C_CH_NUM-1:0]              LB_TMO_O,
  output logic [C_ADDR_WIDTH-1:0]          LB_WADDR_O,
  output logic [C_DATA_WIDTH-1:0]          LB_WDATA_O,
  output logic                             LB_WREQ_O,
  output logic [C_ADDR_WIDTH-1:0]          LB_RADDR_O,
  output logic                             LB_RREQ_O,
  input  logic [C_DATA_WIDTH-1:0]          LB_RDATA_I,
  input  logic                             LB_RFINISH_I
);

  // state  | meaning
  // IDLE   | pick next channel with a full slot (held off while a completion pulse is out)
  // WR     | slave write strobe high for one cycle
  // RD     | slave read strobe high for one cycle
  // RWAIT  | waiting for the slave read return (or the watchdog)
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RWAIT} state_t;

  localparam int PW = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1;

  state_t                    state_q;
  logic [PW-1:0]             ptr_q;
  logic [PW-1:0]             gnt_q;
  logic [C_CH_NUM-1:0]       wr_full;
  logic [C_CH_NUM-1:0]       rd_full;
  logic [C_ADDR_WIDTH-1:0]   wr_addr_q [C_CH_NUM];
  logic [C_DATA_WIDTH-1:0]   wr_data_q [C_CH_NUM];
  logic [C_ADDR_WIDTH-1:0]   rd_addr_q [C_CH_NUM];

  logic                      found;
  logic [PW-1:0]             gnt_ch;
  logic [PW-1:0]             nxt_ptr;
  logic                      grant_ok;
  logic [C_CH_NUM-1:0]       wr_issue;
  logic [C_CH_NUM-1:0]       rd_issue;
  int                        idx;

  always_comb begin
    found  = 1'b0;
    gnt_ch = '0;
    idx    = 0;
    for (int i = 0; i < C_CH_NUM; i++) begin
      idx = (int'(ptr_q) + i) % C_CH_NUM;
      if (!found && (wr_full[idx] || rd_full[idx])) begin
        found  = 1'b1;
        gnt_ch = PW'(idx);
      end
    end
  end

  // Not granting while LB_RFINISH_O is high gives the requester a cycle to see its completion.
  assign grant_ok = (state_q == S_IDLE) && found && !(|LB_RFINISH_O);
  assign nxt_ptr  = (gnt_ch == PW'(C_CH_NUM - 1)) ? '0 : gnt_ch + 1'b1;

  always_comb begin
    wr_issue = '0;
    rd_issue = '0;
    if (grant_ok) begin
      if (wr_full[gnt_ch]) wr_issue[gnt_ch] = 1'b1;
      else                 rd_issue[gnt_ch] = 1'b1;
    end
  end

  // Pending slots: a request landing on the issue edge reloads instead of overflowing.
  always_ff @(posedge LB_CLK_I or negedge LB_RSTN_I) begin
    if (!LB_RSTN_I) begin
      wr_full  <= '0;
      rd_full  <= '0;
      LB_OVF_O <= '0;
      for (int k = 0; k < C_CH_NUM; k++) begin
        wr_addr_q[k] <= '0;
        wr_data_q[k] <= '0;
        rd_addr_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < C_CH_NUM; k++) begin
        if (LB_WREQ_I[k]) begin
          if (wr_full[k] && !wr_issue[k]) begin
            LB_OVF_O[k] <= 1'b1;
          end else begin
            wr_full[k]   <= 1'b1;
            wr_addr_q[k] <= LB_WADDR_I[k*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            wr_data_q[k] <= LB_WDATA_I[k*C_DATA_WIDTH +: C_DATA_WIDTH];
          end
        end else if (wr_issue[k]) begin
          wr_full[k] <= 1'b0;
        end

        if (LB_RREQ_I[k]) begin
          if (rd_full[k] && !rd_issue[k]) begin
            LB_OVF_O[k] <= 1'b1;
          end else begin
            rd_full[k]   <= 1'b1;
            rd_addr_q[k] <= LB_RADDR_I[k*C_ADDR_WIDTH +: C_ADDR_WIDTH];
          end
        end else if (rd_issue[k]) begin
          rd_full[k] <= 1'b0;
        end
      end
    end
  end

`ifdef LB_ARB_WATCHDOG_EN
  localparam int CW = $clog2(C_TIMEOUT) + 1;
  logic [CW-1:0]       wd_cnt;
  logic [C_CH_NUM-1:0] tmo_q;
  assign LB_TMO_O = tmo_q;
`else
  assign LB_TMO_O = '0;
`endif

  always_ff @(posedge LB_CLK_I or negedge LB_RSTN_I) begin
    if (!LB_RSTN_I) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      LB_WREQ_O    <= 1'b0;
      LB_RREQ_O    <= 1'b0;
      LB_WADDR_O   <= '0;
      LB_WDATA_O   <= '0;
      LB_RADDR_O   <= '0;
      LB_RDATA_O   <= '0;
      LB_RFINISH_O <= '0;
`ifdef LB_ARB_WATCHDOG_EN
      wd_cnt       <= '0;
      tmo_q        <= '0;
`endif
    end else begin
      LB_WREQ_O    <= 1'b0;
      LB_RREQ_O    <= 1'b0;
      LB_RFINISH_O <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_ok) begin
            gnt_q <= gnt_ch;
            ptr_q <= nxt_ptr;
            if (wr_full[gnt_ch]) begin
              LB_WADDR_O <= wr_addr_q[gnt_ch];
              LB_WDATA_O <= wr_data_q[gnt_ch];
              LB_WREQ_O  <= 1'b1;
              state_q    <= S_WR;
            end else begin
              LB_RADDR_O <= rd_addr_q[gnt_ch];
              LB_RREQ_O  <= 1'b1;
              state_q    <= S_RD;
            end
          end
        end
        S_WR: state_q <= S_IDLE;
        S_RD: begin
          state_q <= S_RWAIT;
`ifdef LB_ARB_WATCHDOG_EN
          wd_cnt  <= '0;
`endif
        end
        S_RWAIT: begin
          if (LB_RFINISH_I) begin
            for (int k = 0; k < C_CH_NUM; k++) begin
              if (gnt_q == PW'(k)) LB_RDATA_O[k*C_DATA_WIDTH +: C_DATA_WIDTH] <= LB_RDATA_I;
            end
            LB_RFINISH_O[gnt_q] <= 1'b1;
            state_q             <= S_IDLE;
          end
`ifdef LB_ARB_WATCHDOG_EN
          else if (wd_cnt == CW'(C_TIMEOUT - 1)) begin
            for (int k = 0; k < C_CH_NUM; k++) begin
              if (gnt_q == PW'(k)) LB_RDATA_O[k*C_DATA_WIDTH +: C_DATA_WIDTH] <= '1;
            end
            LB_RFINISH_O[gnt_q] <= 1'b1;
            tmo_q[gnt_q]        <= 1'b1;
            state_q             <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lb_arbiter.md
# lb_arbiter

Round-robin local-bus arbiter that shares one downstream local-bus target between C_CH_NUM requesters. It sits between per-channel local-bus masters (register-access engines, host bridges) and the single slave bus. It latches single-cycle write and read request pulses, serialises them, and routes read completions back to the originating channel. Only one read is outstanding on the slave bus at a time, and an optional watchdog bounds how long a read may stay outstanding.

## Interface
- C_ADDR_WIDTH, 16, address width
- C_DATA_WIDTH, 32, data width
- C_CH_NUM, 2, number of requesting channels (2..8)
- C_TIMEOUT, 1024, read watchdog limit in cycles (only used with the watchdog compiled in)

- LB_CLK_I  in  1  the block's only clock
- LB_RSTN_I  in  1  reset, asynchronous, active-low
- LB_WADDR_I  in  C_CH_NUM*C_ADDR_WIDTH  per-channel write address; channel k is slice k
- LB_WDATA_I  in  C_CH_NUM*C_DATA_WIDTH  per-channel write data
- LB_WREQ_I  in  C_CH_NUM  per-channel write request, one-cycle pulse
- LB_RADDR_I  in  C_CH_NUM*C_ADDR_WIDTH  per-channel read address
- LB_RREQ_I  in  C_CH_NUM  per-channel read request, one-cycle pulse
- LB_RDATA_O  out  C_CH_NUM*C_DATA_WIDTH  per-channel read data; holds its last value
- LB_RFINISH_O  out  C_CH_NUM  per-channel read-complete pulse
- LB_OVF_O  out  C_CH_NUM  sticky flag: a request was dropped
- LB_TMO_O  out  C_CH_NUM  sticky flag: a read timed out (constant 0 without the watchdog)
- LB_WADDR_O, LB_WDATA_O, LB_WREQ_O  out  C_ADDR_WIDTH, C_DATA_WIDTH, 1  slave write
- LB_RADDR_O, LB_RREQ_O  out  C_ADDR_WIDTH, 1  slave read
- LB_RDATA_I, LB_RFINISH_I  in  C_DATA_WIDTH, 1  slave read return

## Operation

**Pending slots**
- Each channel has one write slot (address and data) and one read slot (address).
- A request pulse loads its slot.
- If the slot is already full and is not being issued on the same edge, the new request is dropped and the channel's LB_OVF_O bit is set.
- If a request pulse arrives on the same edge its slot is issued, the slot reloads and no overflow is flagged.

**State machine**
- States: IDLE, WR, RD, RWAIT.
- IDLE: if any slot is full, grant the first channel at or after the pointer that has a full slot.
  - Within the granted channel, a write takes priority over a read.
  - A write goes to WR; a read goes to RD.
  - The pointer becomes the granted channel + 1, modulo C_CH_NUM.
- WR: LB_WREQ_O=1 with the registered address and data, for one cycle, then IDLE.
- RD: LB_RREQ_O=1 with the registered address, for one cycle, then RWAIT.
- RWAIT: on LB_RFINISH_I=1, capture LB_RDATA_I into the granted channel's LB_RDATA_O slice and pulse its LB_RFINISH_O for one cycle, then IDLE.

**Other rules**
- LB_RFINISH_I in any state other than RWAIT is ignored.
- LB_WADDR_O, LB_WDATA_O and LB_RADDR_O hold their last value when their strobe is low.
- Reset values: every output is 0, all slots are empty, the pointer is 0, and the state is IDLE.
- Reset mid-transaction: the transaction is abandoned. A late LB_RFINISH_I is ignored because the block is in IDLE.

## Timing
- A request sampled at edge E, with the block in IDLE and no competing slot, drives its slave strobe high from edge E+1 to E+2.
- A write occupies 2 cycles (WR, then IDLE), so back-to-back writes are issued every 2 cycles.
- When LB_RFINISH_I is sampled at edge F, LB_RFINISH_O[k] and the new LB_RDATA_O slice are valid from F to F+1. The next grant's strobe starts at F+2.
- Simultaneous requests from all channels are serviced in pointer order, one per transaction.

## Configuration
- LB_ARB_WATCHDOG_EN defined:
  - RWAIT counts cycles, starting at 0 on entry.
  - If the count reaches C_TIMEOUT-1 without LB_RFINISH_I, the channel gets LB_RDATA_O = all-ones and an LB_RFINISH_O pulse, its LB_TMO_O bit is set, and the state returns to IDLE.
  - If LB_RFINISH_I arrives on that same cycle, the real data wins and no timeout is flagged.
- LB_ARB_WATCHDOG_EN undefined:
  - There is no counter; RWAIT waits indefinitely.
  - LB_TMO_O is tied to 0.

## Test plan
- Simultaneous writes: ch0 write (addr 10, data 0x11223344) and ch1 write (addr 20, data 0xFFEEFFEE) pulsed at edge E -> LB_WREQ_O pulses at E+1 (addr 10) and E+3 (addr 20); LB_OVF_O=0.
- Simultaneous reads: ch0 read 0x8888 and ch1 read 0x9999 pulsed together; slave returns 0xEEEEEEEE and, later, 0x33333333 -> ch0 gets 0xEEEEEEEE with LB_RFINISH_O[0], then LB_RREQ_O for 0x9999 is issued, then ch1 gets 0x33333333 with LB_RFINISH_O[1].
- Overflow: ch0 write pulsed twice while a ch1 read is in RWAIT -> LB_OVF_O[0]=1; only the first write appears on LB_WREQ_O.
- Round-robin fairness: with C_CH_NUM=2, both channels keep their write slots full continuously -> grants alternate 0,1,0,1.
- Watchdog (LB_ARB_WATCHDOG_EN defined, C_TIMEOUT=16): a read with no LB_RFINISH_I -> after 16 cycles in RWAIT, LB_RDATA_O slice = 0xFFFFFFFF, LB_RFINISH_O pulses, LB_TMO_O=1. Without the macro: no completion, LB_TMO_O=0.
- Reset in RWAIT, then LB_RFINISH_I applied -> no LB_RFINISH_O pulse; all outputs stay 0.
